// File: rtl/uart_frame_arbiter_pkg.sv
// Shared types and constants for the UART register-frame arbiter.
// arb_state_t    : arbiter FSM states
// ARB_ADDR_W     : default frame address width
// ARB_DATA_W     : default frame payload width
// ARB_FRAME_BYTES: total bytes in one frame on the wire, as emitted by the frame sender
package uart_frame_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int ARB_ADDR_W      = 8;
  localparam int ARB_DATA_W      = 48;
  localparam int ARB_FRAME_BYTES = 8;

endpackage

// File: rtl/uart_frame_arbiter_if.sv
// Handshake between the arbiter and the register-frame sender.
// tx_en   : launch pulse (arbiter -> sender)
// tx_addr : frame address, held from launch until the frame completes
// tx_regs : frame payload, held from launch until the frame completes
// tx_busy : sender busy level (sender -> arbiter)
interface uart_frame_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 48
) ();

  logic              tx_en;
  logic [ADDR_W-1:0] tx_addr;
  logic [DATA_W-1:0] tx_regs;
  logic              tx_busy;

  modport master (
    output tx_en,
    output tx_addr,
    output tx_regs,
    input  tx_busy
  );

  modport slave (
    input  tx_en,
    input  tx_addr,
    input  tx_regs,
    output tx_busy
  );

endinterface

// File: rtl/uart_frame_arbiter_rr_picker.sv
// Combinational round-robin picker.
// pending : request vector
// last    : index served most recently; search starts at last+1
// valid   : some bit of pending is set
// index   : first set bit found at last+1, last+2, ... modulo N
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         pending,
  input  logic [$clog2(N)-1:0] last,
  output logic                 valid,
  output logic [$clog2(N)-1:0] index
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IDX_W'((int'(last) + off) % N);
      if (!valid && pending[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Shares one register-frame UART sender among N_REQ register sources.
// Each source posts a 1-cycle req with address/payload; captures are held per source,
// served round-robin, one frame at a time, with completion taken from tx_busy.
// clk, rst_n       : clock, synchronous active-low reset
// req/req_addr/req_data : per-source request pulse and sliced frame contents
// ack              : 1-cycle pulse when a source's frame has been fully sent
// pending          : source captured and not yet launched
// grant_id         : source being served / last served
// arb_busy         : arbiter not idle
// err_timeout      : 1-cycle pulse when the sender never went busy after a launch
// tx_if            : sender handshake (master side)
//
// state     | meaning
// IDLE      | waiting for a pending source and a quiet sender
// LAUNCH    | tx_en high for this single cycle
// WAIT_BUSY | waiting for the sender to raise tx_busy, timer running
// WAIT_DONE | frame in flight, waiting for tx_busy to fall
module uart_frame_arbiter
  import uart_frame_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int DATA_W      = ARB_DATA_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           ack,
  output logic [N_REQ-1:0]           pending,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       arb_busy,
  output logic                       err_timeout,
  uart_frame_arbiter_if.master       tx_if
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  arb_state_t        state;
  logic [TMR_W-1:0]  timer;
  logic [ADDR_W-1:0] hold_addr [N_REQ];
  logic [DATA_W-1:0] hold_data [N_REQ];
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;

  rr_picker #(.N(N_REQ)) u_picker (
    .pending (pending),
    .last    (grant_id),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  // Hold registers need no reset: they are only read after a capture has set pending.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        hold_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
        hold_data[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= '0;
      ack           <= '0;
      tx_if.tx_en   <= 1'b0;
      tx_if.tx_addr <= '0;
      tx_if.tx_regs <= '0;
      grant_id      <= IDX_W'(N_REQ - 1);
      err_timeout   <= 1'b0;
      timer         <= '0;
    end else begin
      ack         <= '0;
      tx_if.tx_en <= 1'b0;
      err_timeout <= 1'b0;
      // Fresh captures first; the per-bit updates below override where they apply.
      pending     <= pending | req;

      case (state)
        IDLE: begin
          if (pick_valid && !tx_if.tx_busy) begin
            grant_id           <= pick_idx;
            tx_if.tx_addr      <= hold_addr[pick_idx];
            tx_if.tx_regs      <= hold_data[pick_idx];
            // A same-cycle re-request keeps the source pending with its new data.
            pending[pick_idx]  <= req[pick_idx];
            tx_if.tx_en        <= 1'b1;
            state              <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_if.tx_busy) begin
            state <= WAIT_DONE;
          end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
            err_timeout       <= 1'b1;
            pending[grant_id] <= 1'b1;
            state             <= IDLE;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_if.tx_busy) begin
            ack[grant_id] <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arb_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Randomized bench for uart_frame_arbiter with a transaction-level reference model.
module tb_uart_frame_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 48;
  localparam int TO = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic [N-1:0]    pending;
  logic [1:0]      grant_id;
  logic            arb_busy;
  logic            err_timeout;

  uart_frame_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) tx_if ();

  uart_frame_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .ack         (ack),
    .pending     (pending),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout),
    .tx_if       (tx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0]  m_pend;
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N];
  int            m_last;
  bit            m_inflight;
  bit            m_busy_seen;
  int            m_gid;
  int            launch_cyc;
  int            cyc;
  logic          prev_busy;
  int            ack_cnt [N];
  int            launch_cnt [N];
  logic [DW-1:0] last_regs [N];
  int            n_err;
  int            ack_total;
  int            grant_log[$];
  int            ack_log[$];
  int            ignore_cnt;

  // Round-robin rule: the pending source closest after the last one served wins.
  function automatic int model_pick(input logic [N-1:0] p, input int last);
    int best, bd, d;
    best = -1;
    bd   = N + 1;
    for (int i = 0; i < N; i++) begin
      if (p[i]) begin
        d = (i - last - 1 + 2 * N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  initial begin
    logic [N-1:0] snap;
    logic [N-1:0] exp_ack;
    bit           exp_err;
    bit           event_seen;
    int           pick;
    m_pend = '0; m_last = N - 1; m_inflight = 0; m_busy_seen = 0; m_gid = 0;
    launch_cyc = 0; cyc = 0; prev_busy = 0; n_err = 0; ack_total = 0;
    for (int i = 0; i < N; i++) begin
      ack_cnt[i] = 0; launch_cnt[i] = 0; last_regs[i] = '0; m_addr[i] = '0; m_data[i] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        m_pend = '0; m_last = N - 1; m_inflight = 0; m_busy_seen = 0;
        prev_busy = tx_if.tx_busy;
        continue;
      end
      snap = m_pend;
      event_seen = (req != 0) || (ack != 0) || err_timeout || tx_if.tx_en;

      exp_ack = '0;
      if (m_inflight && m_busy_seen && prev_busy && !tx_if.tx_busy) exp_ack[m_gid] = 1'b1;
      if (exp_ack != 0 || ack != 0) begin
        check("ack", ack, exp_ack);
        if (exp_ack != 0) begin
          ack_cnt[m_gid]++; ack_total++; ack_log.push_back(m_gid); m_inflight = 0;
        end
      end

      exp_err = m_inflight && !m_busy_seen && ((cyc - launch_cyc) == TO + 1);
      if (exp_err || err_timeout) begin
        check("err_timeout", err_timeout, exp_err);
        if (exp_err) begin
          n_err++; m_pend[m_gid] = 1'b1; m_inflight = 0;
        end
      end

      if (tx_if.tx_en) begin
        check("tx_en_while_inflight", m_inflight, 0);
        check("tx_en_while_busy", tx_if.tx_busy, 0);
        pick = model_pick(snap, m_last);
        if (pick < 0) check("tx_en_spurious", 1, 0);
        else begin
          check("grant_id", grant_id, pick);
          check("tx_addr", tx_if.tx_addr, m_addr[pick]);
          check("tx_regs", tx_if.tx_regs, m_data[pick]);
          m_pend[pick] = 1'b0; m_last = pick; m_gid = pick;
          m_inflight = 1; m_busy_seen = 0; launch_cyc = cyc;
          launch_cnt[pick]++; grant_log.push_back(pick); last_regs[pick] = tx_if.tx_regs;
        end
      end

      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          m_pend[i] = 1'b1;
          m_addr[i] = req_addr[i*AW +: AW];
          m_data[i] = req_data[i*DW +: DW];
        end
      end
      if (m_inflight && tx_if.tx_busy) m_busy_seen = 1;
      if (event_seen) check("pending", pending, m_pend);
      prev_busy = tx_if.tx_busy;
    end
  end

  // ---------------- sender model ----------------
  initial begin
    int d;
    tx_if.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_if.tx_en) begin
        if (ignore_cnt > 0) ignore_cnt--;
        else begin
          d = $urandom_range(0, 2);
          repeat (d + 1) @(negedge clk);
          tx_if.tx_busy = 1'b1;
          d = $urandom_range(3, 6);
          repeat (d) @(negedge clk);
          tx_if.tx_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req[i] = 1'b1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {16'($urandom()), 32'($urandom())};
  endfunction

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(pending == 0 && !arb_busy && !tx_if.tx_busy) && n < 3000);
    check(tag, n < 3000, 1);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!tx_if.tx_busy && n < 200);
    check(tag, n < 200, 1);
  endtask

  // ---------------- tests ----------------
  initial begin
    int base, issued, n, a0, l0, l1, e0, id;
    rst_n = 1'b0; req = '0; req_addr = '0; req_data = '0; ignore_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant_id, 2'd3);
    check("rst_pending", pending, 0);
    check("rst_tx_en", tx_if.tx_en, 0);
    check("rst_tx_addr", tx_if.tx_addr, 0);
    check("rst_tx_regs", tx_if.tx_regs, 0);
    check("rst_arb_busy", arb_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single request, 2-cycle launch latency
    load(2, 8'h15, 48'h0123_4567_89AB);
    @(posedge clk); #1;
    check("t1_no_en_yet", tx_if.tx_en, 0);
    check("t1_pending", pending, 4'b0100);
    @(negedge clk); req = '0;
    @(posedge clk); #1;
    check("t1_tx_en", tx_if.tx_en, 1);
    check("t1_tx_addr", tx_if.tx_addr, 8'h15);
    check("t1_tx_regs", tx_if.tx_regs, 48'h0123_4567_89AB);
    wait_quiet("t1_quiet");
    check("t1_ack2", ack_cnt[2], 1);
    check("t1_pending_end", pending, 0);

    // 2: simultaneous requests 0 and 1
    base = grant_log.size(); a0 = ack_log.size();
    @(negedge clk);
    load(0, 8'h20, rnd_data()); load(1, 8'h21, rnd_data());
    @(negedge clk); req = '0;
    wait_quiet("t2_quiet");
    check("t2_launches", grant_log.size() - base, 2);
    if (ack_log.size() - a0 == 2) begin
      check("t2_first_ack", ack_log[a0], 0);
      check("t2_second_ack", ack_log[a0 + 1], 1);
    end else check("t2_ack_count", ack_log.size() - a0, 2);

    // 3: all four re-request on every ack, 12 frames; last served was 1 so order starts at 2
    base = grant_log.size();
    for (int i = 0; i < N; i++) l0 = launch_cnt[i];
    @(negedge clk);
    for (int i = 0; i < N; i++) load(i, 8'(8'h30 + i), rnd_data());
    @(negedge clk); req = '0;
    issued = 4; n = 0;
    while (issued < 12 && n < 2000) begin
      @(posedge clk); #1; n++;
      if (ack != 0) begin
        id = 0;
        for (int i = 0; i < N; i++) if (ack[i]) id = i;
        @(negedge clk); load(id, 8'($urandom()), rnd_data());
        @(negedge clk); req = '0;
        issued++;
      end
    end
    check("t3_reissue_bound", n < 2000, 1);
    wait_quiet("t3_quiet");
    check("t3_count", grant_log.size() - base, 12);
    if (grant_log.size() - base >= 12)
      for (int k = 0; k < 12; k++) check("t3_order", grant_log[base + k], (2 + k) % N);

    // 4: sender ignores the first launch -> timeout, retry, single ack
    e0 = n_err; a0 = ack_cnt[3]; l0 = launch_cnt[3];
    ignore_cnt = 1;
    @(negedge clk); load(3, 8'h44, rnd_data());
    @(negedge clk); req = '0;
    wait_quiet("t4_quiet");
    check("t4_err_count", n_err - e0, 1);
    check("t4_launches", launch_cnt[3] - l0, 2);
    check("t4_acks", ack_cnt[3] - a0, 1);

    // 5: re-requests for source 1 while its frame is in flight; latest data wins
    a0 = ack_cnt[1]; l1 = launch_cnt[1];
    @(negedge clk); load(1, 8'h51, 48'h0000_0000_0AAA);
    @(negedge clk); req = '0;
    wait_busy("t5_busy");
    @(negedge clk); load(1, 8'h52, 48'hAAAA_AAAA_AAAA);
    @(negedge clk); load(1, 8'h53, 48'hBBBB_BBBB_BBBB);
    @(negedge clk); req = '0;
    wait_quiet("t5_quiet");
    check("t5_launches", launch_cnt[1] - l1, 2);
    check("t5_acks", ack_cnt[1] - a0, 2);
    check("t5_data_b", last_regs[1], 48'hBBBB_BBBB_BBBB);

    // 6: reset while a frame is in flight with three sources pending
    @(negedge clk);
    for (int i = 0; i < N; i++) load(i, 8'(8'h60 + i), rnd_data());
    @(negedge clk); req = '0;
    wait_busy("t6_busy");
    @(negedge clk); rst_n = 1'b0;
    a0 = ack_total;
    @(posedge clk); #1;
    check("t6_pending", pending, 0);
    check("t6_ack", ack, 0);
    check("t6_tx_en", tx_if.tx_en, 0);
    check("t6_tx_addr", tx_if.tx_addr, 0);
    check("t6_tx_regs", tx_if.tx_regs, 0);
    check("t6_grant", grant_id, 2'd3);
    check("t6_err", err_timeout, 0);
    check("t6_arb_busy", arb_busy, 0);
    @(negedge clk); rst_n = 1'b1;
    wait_quiet("t6_quiet");
    check("t6_no_ack", ack_total - a0, 0);
    base = grant_log.size();
    @(negedge clk);
    load(3, 8'h73, rnd_data()); load(0, 8'h70, rnd_data()); load(2, 8'h72, rnd_data());
    @(negedge clk); req = '0;
    wait_quiet("t6_after_quiet");
    if (grant_log.size() > base) check("t6_first_grant", grant_log[base], 0);
    else check("t6_first_grant_missing", grant_log.size() - base, 3);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req = '0;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) load(i, 8'($urandom()), rnd_data());
    end
    @(negedge clk); req = '0;
    wait_quiet("rand_quiet");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
